axi4_slave_wr_responder: RTL and testbench

AXI4 write-channel responder (slave end) that terminates one slave port of the axi4_interconnect_m17s17 matrix. Accepts AW/W bursts, writes strobed bytes into internal word memory and returns B responses. A combinational debug read port lets the bench check memory contents. One burst in flight at a time.

---
 rtl/axi4_slave_wr_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_axi4_slave_wr_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_wr_responder.sv
// AXI4 write responder: accepts one AW/W burst at a time into word memory, answers on B. Optional macro AXI_WR_RESP_DELAY_EN adds RESP_DELAY cycles before B.
// Latency: AW handshake N -> wready at N+1; last W handshake M -> bvalid at M+1 (M+1+RESP_DELAY with the macro defined).
// Backpressure: awready only in IDLE, wready only in DATA; bvalid/bid/bresp hold until bready.
module axi4_slave_wr_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    RESP_DELAY = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [ID_WIDTH-1:0]          awid,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [7:0]                   awlen,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [ID_WIDTH-1:0]          bid,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_idx,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);

    localparam int                    BYTES     = DATA_WIDTH / 8;
    localparam int                    LOG2B     = $clog2(BYTES);
    localparam int                    IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   SPAN      = (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_WAIT, ST_RESP} state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [1:0]              burst_q, burst_d;
    logic [8:0]              cnt_q, cnt_d;
    logic                    nowr_q, nowr_d;
    logic                    slverr_q, slverr_d;
    logic                    decerr_q, decerr_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
`ifdef AXI_WR_RESP_DELAY_EN
    localparam int DLY_W = (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;
    logic [DLY_W-1:0]        dly_q, dly_d;
`endif

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    aw_hs, w_hs, b_hs;
    logic                    aw_bad, in_range, beyond, beat_live, beat_dec, beat_slv;
    logic                    mem_we, dec_n, slv_n;
    logic [ADDR_WIDTH-1:0]   off, wrap_mask, incr_addr, next_addr;
    logic [IDX_W-1:0]        mem_idx;

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bresp     = bresp_q;
    assign bid       = id_q;
    assign dbg_rdata = mem[dbg_idx];

    assign aw_hs = awvalid && awready_q;
    assign w_hs  = wvalid && wready_q;
    assign b_hs  = bvalid_q && bready;

    // Bursts rejected at AW time still consume their W beats but never write.
    assign aw_bad = (awburst == 2'b11)
                 || ((awburst == 2'b10) && !((awlen == 8'd1) || (awlen == 8'd3) ||
                                             (awlen == 8'd7) || (awlen == 8'd15)))
                 || ((awaddr & LANE_MASK) != '0);

    assign off       = addr_q - BASE_ADDR;
    assign in_range  = (addr_q >= BASE_ADDR) && ({1'b0, off} < SPAN);
    assign mem_idx   = IDX_W'(off >> LOG2B);
    assign beyond    = cnt_q > {1'b0, len_q};
    assign beat_live = w_hs && !nowr_q && !beyond;
    assign mem_we    = beat_live && in_range;
    assign beat_dec  = beat_live && !in_range;
    assign beat_slv  = w_hs && (wlast != (cnt_q == {1'b0, len_q}));

    // WRAP window is (len+1)*BYTES; len is 2^k-1 so the window mask is len:lane bits.
    assign wrap_mask = (ADDR_WIDTH'(len_q) << LOG2B) | LANE_MASK;
    assign incr_addr = addr_q + STEP;

    always_comb begin
        next_addr = addr_q;
        case (burst_q)
            2'b01:   next_addr = incr_addr;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = addr_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        nowr_d    = nowr_q;
        slverr_d  = slverr_q;
        decerr_d  = decerr_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        dec_n     = decerr_q | beat_dec;
        slv_n     = slverr_q | beat_slv;
`ifdef AXI_WR_RESP_DELAY_EN
        dly_d     = dly_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    id_d      = awid;
                    addr_d    = awaddr;
                    len_d     = awlen;
                    burst_d   = awburst;
                    cnt_d     = '0;
                    nowr_d    = aw_bad;
                    slverr_d  = aw_bad;
                    decerr_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    addr_d   = next_addr;
                    cnt_d    = cnt_q[8] ? cnt_q : cnt_q + 9'd1;
                    decerr_d = dec_n;
                    slverr_d = slv_n;
                    if (wlast) begin
                        wready_d = 1'b0;
                        bresp_d  = dec_n ? 2'b11 : (slv_n ? 2'b10 : 2'b00);
`ifdef AXI_WR_RESP_DELAY_EN
                        if (RESP_DELAY == 0) begin
                            bvalid_d = 1'b1;
                            state_d  = ST_RESP;
                        end else begin
                            dly_d   = DLY_W'(RESP_DELAY);
                            state_d = ST_WAIT;
                        end
`else
                        bvalid_d = 1'b1;
                        state_d  = ST_RESP;
`endif
                    end
                end
            end
`ifdef AXI_WR_RESP_DELAY_EN
            ST_WAIT: begin
                dly_d = dly_q - 1'b1;
                if (dly_q <= DLY_W'(1)) begin
                    bvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                if (b_hs) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            nowr_q    <= 1'b0;
            slverr_q  <= 1'b0;
            decerr_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
`ifdef AXI_WR_RESP_DELAY_EN
            dly_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            nowr_q    <= nowr_d;
            slverr_q  <= slverr_d;
            decerr_q  <= decerr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
`ifdef AXI_WR_RESP_DELAY_EN
            dly_q     <= dly_d;
`endif
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) mem[mem_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_slave_wr_responder.sv
// Directed bench for axi4_slave_wr_responder (default build): bursts, errors, B backpressure, reset abort.
module tb_axi4_slave_wr_responder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [9:0]  dbg_idx;
    logic [31:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    axi4_slave_wr_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024),
        .BASE_ADDR(32'h0), .RESP_DELAY(4)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_idx(dbg_idx), .dbg_rdata(dbg_rdata)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        logic hs;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = awready;
            tick();
        end
        awvalid = 1'b0;
        check("aw_handshake", {31'd0, hs}, 32'd1);
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic hs;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = wready;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("w_handshake", {31'd0, hs}, 32'd1);
    endtask

    task automatic b_take(input string tag, input logic [3:0] id, input logic [1:0] resp);
        for (int i = 0; i < 20 && !bvalid; i++) tick();
        check({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
        check({tag, "_bid"}, {28'd0, bid}, {28'd0, id});
        check({tag, "_bresp"}, {30'd0, bresp}, {30'd0, resp});
        bready = 1'b1;
        tick();
        check({tag, "_bvalid_drop"}, {31'd0, bvalid}, 32'd0);
        check({tag, "_awready_back"}, {31'd0, awready}, 32'd1);
    endtask

    task automatic mem_chk(input string tag, input int idx, input logic [31:0] exp);
        dbg_idx = 10'(idx);
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b1; dbg_idx = '0;
        tick(); tick();
        check("rst_awready", {31'd0, awready}, 32'd1);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_bid",     {28'd0, bid},     32'd0);
        check("rst_bresp",   {30'd0, bresp},   32'd0);
        aresetn = 1'b1;
        tick();

        // W presented with no AW must be held off
        wvalid = 1'b1; wdata = 32'hDEAD0000; wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            check("w_holdoff", {31'd0, wready}, 32'd0);
            tick();
        end
        wvalid = 1'b0;

        // INCR 0x10 len 3 with latency checks
        aw_send(4'h5, 32'h10, 8'd3, 2'b01);
        check("incr_wready_n1", {31'd0, wready}, 32'd1);
        check("incr_awready_n1", {31'd0, awready}, 32'd0);
        w_beat(32'hA0, 4'hF, 1'b0);
        w_beat(32'hA1, 4'hF, 1'b0);
        w_beat(32'hA2, 4'hF, 1'b0);
        w_beat(32'hA3, 4'hF, 1'b1);
        check("incr_b_latency", {31'd0, bvalid}, 32'd1);
        b_take("incr", 4'h5, 2'b00);
        mem_chk("incr_mem4", 4, 32'hA0);
        mem_chk("incr_mem5", 5, 32'hA1);
        mem_chk("incr_mem6", 6, 32'hA2);
        mem_chk("incr_mem7", 7, 32'hA3);

        // WRAP 0x38 len 3: window 0x30-0x3F
        aw_send(4'hA, 32'h38, 8'd3, 2'b10);
        w_beat(32'd1, 4'hF, 1'b0);
        w_beat(32'd2, 4'hF, 1'b0);
        w_beat(32'd3, 4'hF, 1'b0);
        w_beat(32'd4, 4'hF, 1'b1);
        b_take("wrap", 4'hA, 2'b00);
        mem_chk("wrap_mem14", 14, 32'd1);
        mem_chk("wrap_mem15", 15, 32'd2);
        mem_chk("wrap_mem12", 12, 32'd3);
        mem_chk("wrap_mem13", 13, 32'd4);

        // Clear words 0 and 16 so later partial/no-write cases compare against known data
        aw_send(4'h1, 32'h0, 8'd0, 2'b01);
        w_beat(32'h0, 4'hF, 1'b1);
        b_take("clr0", 4'h1, 2'b00);
        aw_send(4'h1, 32'h40, 8'd0, 2'b01);
        w_beat(32'h0, 4'hF, 1'b1);
        b_take("clr16", 4'h1, 2'b00);

        // FIXED with lane strobes
        aw_send(4'h2, 32'h0, 8'd2, 2'b00);
        w_beat(32'h00000011, 4'h1, 1'b0);
        w_beat(32'h00002200, 4'h2, 1'b0);
        w_beat(32'h00330000, 4'h4, 1'b1);
        b_take("fixed", 4'h2, 2'b00);
        mem_chk("fixed_mem0", 0, 32'h00332211);

        // Last word then past the end: DECERR, beat 1 dropped
        aw_send(4'h3, 32'hFFC, 8'd1, 2'b01);
        w_beat(32'hDEADBEEF, 4'hF, 1'b0);
        w_beat(32'h12345678, 4'hF, 1'b1);
        b_take("decerr", 4'h3, 2'b11);
        mem_chk("decerr_mem1023", 1023, 32'hDEADBEEF);
        mem_chk("decerr_mem0", 0, 32'h00332211);

        // Reserved burst type: SLVERR, no write
        aw_send(4'h4, 32'h40, 8'd0, 2'b11);
        w_beat(32'h55, 4'hF, 1'b1);
        b_take("rsvd", 4'h4, 2'b10);
        mem_chk("rsvd_mem16", 16, 32'h0);

        // WRAP with illegal length: SLVERR, no write
        aw_send(4'h6, 32'h40, 8'd2, 2'b10);
        w_beat(32'hBAD0, 4'hF, 1'b0);
        w_beat(32'hBAD1, 4'hF, 1'b0);
        w_beat(32'hBAD2, 4'hF, 1'b1);
        b_take("wraplen", 4'h6, 2'b10);
        mem_chk("wraplen_mem16", 16, 32'h0);

        // Misaligned start: SLVERR, no write
        aw_send(4'h7, 32'h42, 8'd0, 2'b01);
        w_beat(32'hBAD3, 4'hF, 1'b1);
        b_take("misalign", 4'h7, 2'b10);
        mem_chk("misalign_mem16", 16, 32'h0);

        // Early wlast: beats written, SLVERR
        aw_send(4'h9, 32'h50, 8'd3, 2'b01);
        w_beat(32'h77, 4'hF, 1'b0);
        w_beat(32'h88, 4'hF, 1'b1);
        b_take("early", 4'h9, 2'b10);
        mem_chk("early_mem20", 20, 32'h77);
        mem_chk("early_mem21", 21, 32'h88);

        // B backpressure: response held, AW refused meanwhile
        bready = 1'b0;
        aw_send(4'hC, 32'h60, 8'd0, 2'b01);
        w_beat(32'hC0FFEE, 4'hF, 1'b1);
        awvalid = 1'b1; awaddr = 32'h64; awid = 4'hD; awlen = 8'd0; awburst = 2'b01;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid",  {31'd0, bvalid},  32'd1);
            check("bp_bid",     {28'd0, bid},     32'h0000000C);
            check("bp_bresp",   {30'd0, bresp},   32'd0);
            check("bp_awready", {31'd0, awready}, 32'd0);
            tick();
        end
        awvalid = 1'b0;
        b_take("bp", 4'hC, 2'b00);
        mem_chk("bp_mem24", 24, 32'hC0FFEE);

        // Reset in the middle of a burst
        aw_send(4'h3, 32'h70, 8'd3, 2'b01);
        w_beat(32'hAB, 4'hF, 1'b0);
        aresetn = 1'b0;
        #1;
        check("midrst_awready", {31'd0, awready}, 32'd1);
        check("midrst_wready",  {31'd0, wready},  32'd0);
        check("midrst_bvalid",  {31'd0, bvalid},  32'd0);
        check("midrst_bid",     {28'd0, bid},     32'd0);
        check("midrst_bresp",   {30'd0, bresp},   32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        mem_chk("midrst_mem28", 28, 32'hAB);
        aw_send(4'h6, 32'h80, 8'd0, 2'b01);
        w_beat(32'h99, 4'hF, 1'b1);
        b_take("postrst", 4'h6, 2'b00);
        mem_chk("postrst_mem32", 32, 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
